// File: rtl/ps2_host_ctrl_if.sv
// Byte-stream side of the PS/2 host controller: TX command bytes in, RX bytes out,
// plus the one-cycle status pulses seen by the register front end.
interface ps2_host_ctrl_if;
  logic       tx_valid_i;
  logic [7:0] tx_data_i;
  logic       tx_ready_o;
  logic       rx_valid_o;
  logic [7:0] rx_data_o;
  logic       rx_ready_i;
  logic       rx_err_o;
  logic       rx_ovf_o;
  logic       tx_err_o;

  modport master (
    output tx_valid_i, tx_data_i, rx_ready_i,
    input  tx_ready_o, rx_valid_o, rx_data_o, rx_err_o, rx_ovf_o, tx_err_o
  );

  modport slave (
    input  tx_valid_i, tx_data_i, rx_ready_i,
    output tx_ready_o, rx_valid_o, rx_data_o, rx_err_o, rx_ovf_o, tx_err_o
  );
endinterface

// File: rtl/ps2_host_ctrl.sv
// PS/2 host engine: synchronizes and filters the open-drain clock/data pair,
// receives device frames into a small FIFO and sends host commands with inhibit/RTS.
module ps2_host_ctrl #(
  parameter int FifoDepth     = 4,
  parameter int FilterLen     = 8,
  parameter int InhibitCycles = 5000,
  parameter int TimeoutCycles = 100000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ps2_clk_i,
  input  logic            ps2_dat_i,
  output logic            ps2_clk_o,
  output logic            ps2_dat_o,
  output logic            ps2_clk_t,
  output logic            ps2_dat_t,
  ps2_host_ctrl_if.slave  bus,
  output logic            irq_o
);
  localparam int PtrW   = $clog2(FifoDepth);
  localparam int CntW   = PtrW + 1;
  localparam int FltW   = $clog2(FilterLen + 1);
  localparam int TmrMax = (InhibitCycles > TimeoutCycles) ? InhibitCycles : TimeoutCycles;
  localparam int TmrW   = $clog2(TmrMax + 1);

  typedef enum logic [2:0] {IDLE, RX, INHIBIT, RTS, TX, ACK, WAIT_IDLE} state_t;

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  // Stage p0/p1: two-flop synchronizers
  logic clk_meta_p0, clk_sync_p1, dat_meta_p0, dat_sync_p1;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_meta_p0 <= 1'b1;
      clk_sync_p1 <= 1'b1;
      dat_meta_p0 <= 1'b1;
      dat_sync_p1 <= 1'b1;
    end else begin
      clk_meta_p0 <= ps2_clk_i;
      clk_sync_p1 <= clk_meta_p0;
      dat_meta_p0 <= ps2_dat_i;
      dat_sync_p1 <= dat_meta_p0;
    end
  end

  // Stage p2: glitch filters; fall pulses together with the filtered clock update
  logic            clk_filt_p2, dat_filt_p2, fall_p2;
  logic [FltW-1:0] clk_cnt, dat_cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_filt_p2 <= 1'b1;
      dat_filt_p2 <= 1'b1;
      fall_p2     <= 1'b0;
      clk_cnt     <= '0;
      dat_cnt     <= '0;
    end else begin
      fall_p2 <= 1'b0;
      if (clk_sync_p1 == clk_filt_p2) clk_cnt <= '0;
      else if (clk_cnt == FltW'(FilterLen - 1)) begin
        clk_cnt     <= '0;
        clk_filt_p2 <= clk_sync_p1;
        fall_p2     <= ~clk_sync_p1;
      end else clk_cnt <= clk_cnt + 1'b1;
      if (dat_sync_p1 == dat_filt_p2) dat_cnt <= '0;
      else if (dat_cnt == FltW'(FilterLen - 1)) begin
        dat_cnt     <= '0;
        dat_filt_p2 <= dat_sync_p1;
      end else dat_cnt <= dat_cnt + 1'b1;
    end
  end

  state_t          state_q, state_d;
  logic [3:0]      bit_q, bit_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic [8:0]      rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
  logic            clk_t_q, clk_t_d, dat_t_q, dat_t_d;
  logic            rx_err_q, rx_err_d, tx_err_q, tx_err_d, ovf_q, ovf_d;
  logic            tx_ready, tx_hs, timed, push, pop, full, wr_en;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [7:0]      mem [FifoDepth];
  logic            irq_q;

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    tmr_d      = tmr_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    clk_t_d    = clk_t_q;
    dat_t_d    = dat_t_q;
    rx_err_d   = 1'b0;
    tx_err_d   = 1'b0;
    push       = 1'b0;
    tx_ready   = (state_q == IDLE) && !fall_p2 && !rst_i;
    tx_hs      = bus.tx_valid_i && tx_ready;
    timed      = state_q inside {RX, TX, ACK, WAIT_IDLE};
    if (timed) tmr_d = fall_p2 ? '0 : tmr_q + 1'b1;
    case (state_q)
      IDLE: begin
        bit_d = '0;
        tmr_d = '0;
        if (fall_p2 && !dat_filt_p2) state_d = RX;
        else if (tx_hs) begin
          state_d    = INHIBIT;
          clk_t_d    = 1'b0;
          tx_shift_d = {odd_par(bus.tx_data_i), bus.tx_data_i};
        end
      end
      RX: if (fall_p2) begin
        if (bit_q == 4'd9) begin
          state_d = IDLE;
          if (rx_shift_q[8] == odd_par(rx_shift_q[7:0]) && dat_filt_p2) push = 1'b1;
          else rx_err_d = 1'b1;
        end else begin
          rx_shift_d = {dat_filt_p2, rx_shift_q[8:1]};
          bit_d      = bit_q + 1'b1;
        end
      end
      INHIBIT: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == TmrW'(InhibitCycles - 1)) begin
          state_d = RTS;
          clk_t_d = 1'b1;
          dat_t_d = 1'b0;
          tmr_d   = '0;
        end
      end
      RTS: begin
        state_d = TX;
        bit_d   = '0;
        tmr_d   = '0;
      end
      // Nine falls shift out data+parity, the tenth releases the line for stop
      TX: if (fall_p2) begin
        if (bit_q == 4'd9) begin
          dat_t_d = 1'b1;
          state_d = ACK;
          bit_d   = '0;
        end else begin
          dat_t_d    = tx_shift_q[0];
          tx_shift_d = {1'b1, tx_shift_q[8:1]};
          bit_d      = bit_q + 1'b1;
        end
      end
      ACK: if (fall_p2) begin
        state_d  = WAIT_IDLE;
        tx_err_d = dat_filt_p2;
      end
      WAIT_IDLE: if (clk_filt_p2 && dat_filt_p2) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (timed && !fall_p2 && tmr_q == TmrW'(TimeoutCycles - 1)) begin
      state_d  = IDLE;
      clk_t_d  = 1'b1;
      dat_t_d  = 1'b1;
      push     = 1'b0;
      rx_err_d = (state_q == RX);
      tx_err_d = (state_q != RX);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      bit_q    <= '0;
      tmr_q    <= '0;
      clk_t_q  <= 1'b1;
      dat_t_q  <= 1'b1;
      rx_err_q <= 1'b0;
      tx_err_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      tmr_q    <= tmr_d;
      clk_t_q  <= clk_t_d;
      dat_t_q  <= dat_t_d;
      rx_err_q <= rx_err_d;
      tx_err_q <= tx_err_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    rx_shift_q <= rx_shift_d;
    tx_shift_q <= tx_shift_d;
    if (wr_en) mem[wr_ptr_q] <= rx_shift_q[7:0];
  end

  // A pop frees the slot in the same cycle, so push+pop while full is accepted
  assign pop   = bus.rx_ready_i && (count_q != '0);
  assign full  = (count_q == CntW'(FifoDepth));
  assign wr_en = push && (!full || pop);
  assign ovf_d = push && full && !pop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      irq_q <= (count_q != '0);
    end
  end

  assign ps2_clk_o      = 1'b0;
  assign ps2_dat_o      = 1'b0;
  assign ps2_clk_t      = clk_t_q;
  assign ps2_dat_t      = dat_t_q;
  assign bus.tx_ready_o = tx_ready;
  assign bus.rx_valid_o = (count_q != '0);
  assign bus.rx_data_o  = mem[rd_ptr_q];
  assign bus.rx_err_o   = rx_err_q;
  assign bus.rx_ovf_o   = ovf_q;
  assign bus.tx_err_o   = tx_err_q;
  assign irq_o          = irq_q;
endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Bench for ps2_host_ctrl: an open-drain PS/2 device model drives frames, a queue
// scoreboard checks the RX byte stream, and pulse monitors count error events.
module tb_ps2_host_ctrl;
  localparam int FL    = 4;
  localparam int INH   = 50;
  localparam int TMO   = 400;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;
  logic ps2_clk_o, ps2_dat_o, ps2_clk_t, ps2_dat_t, irq;
  wire  clk_line = ps2_clk_t ? dev_clk : 1'b0;
  wire  dat_line = ps2_dat_t ? dev_dat : 1'b0;

  ps2_host_ctrl_if bus ();

  ps2_host_ctrl #(.FifoDepth(DEPTH), .FilterLen(FL), .InhibitCycles(INH), .TimeoutCycles(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .ps2_clk_i(clk_line), .ps2_dat_i(dat_line),
    .ps2_clk_o(ps2_clk_o), .ps2_dat_o(ps2_dat_o),
    .ps2_clk_t(ps2_clk_t), .ps2_dat_t(ps2_dat_t),
    .bus(bus), .irq_o(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int rx_err_cnt = 0, ovf_cnt = 0, tx_err_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor and pulse counters, sampled on the falling edge
  always @(negedge clk) begin
    if (rx_err_cnt < 1000 && bus.rx_err_o) rx_err_cnt++;
    if (bus.rx_ovf_o) ovf_cnt++;
    if (bus.tx_err_o) tx_err_cnt++;
    if (bus.rx_valid_o && bus.rx_ready_i) begin
      if (exp_q.size() == 0) check("rx_unexpected", {24'd0, bus.rx_data_o}, 32'hFFFF_FFFF);
      else check("rx_data", {24'd0, bus.rx_data_o}, {24'd0, exp_q.pop_front()});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Device-to-host frame; sync_pop asserts rx_ready for the single cycle of the stop-bit push
  task automatic dev_send(input logic [7:0] b, input logic par, input bit sync_pop);
    logic [10:0] bits;
    bits = {1'b1, par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      dev_dat = bits[i];
      tick(10);
      dev_clk = 1'b0;
      if (i == 10 && sync_pop) begin
        tick(2 + FL);
        bus.rx_ready_i = 1'b1;
        tick(1);
        bus.rx_ready_i = 1'b0;
        tick(20 - 3 - FL);
      end else tick(20);
      dev_clk = 1'b1;
      tick(10);
    end
    dev_dat = 1'b1;
  endtask

  task automatic host_start(input logic [7:0] b);
    int n;
    n = 0;
    while (!bus.tx_ready_o && n < 2000) begin tick(1); n++; end
    check("tx_ready_wait", {31'd0, bus.tx_ready_o}, 32'd1);
    bus.tx_valid_i = 1'b1;
    bus.tx_data_i  = b;
    tick(1);
    bus.tx_valid_i = 1'b0;
    check("clk_inhibit_next", {31'd0, ps2_clk_t}, 32'd0);
    n = 0;
    while (ps2_clk_t == 1'b0 && n < 4 * INH) begin tick(1); n++; end
    check("inhibit_len", n, INH);
    check("rts_start_bit", {30'd0, ps2_clk_t, ps2_dat_t}, 32'b10);
  endtask

  // Device side of a host-to-device frame: samples on rising clock, optionally ACKs
  task automatic dev_host_rx(input bit ack, input int npulse, output logic [9:0] bits);
    bits = '0;
    tick(30);
    for (int i = 0; i < npulse; i++) begin
      dev_clk = 1'b0;
      tick(20);
      if (i < 10) bits[i] = dat_line;
      dev_clk = 1'b1;
      tick(20);
    end
    if (ack && npulse == 10) begin
      dev_dat = 1'b0;
      tick(10);
      dev_clk = 1'b0;
      tick(20);
      dev_clk = 1'b1;
      tick(20);
      dev_dat = 1'b1;
      tick(20);
    end
  endtask

  initial begin
    logic [9:0] got;
    int e_rx, e_ovf, e_tx, n;
    bus.tx_valid_i = 1'b0;
    bus.tx_data_i  = 8'h00;
    bus.rx_ready_i = 1'b0;

    tick(5);
    check("rst_clk_t", {31'd0, ps2_clk_t}, 32'd1);
    check("rst_dat_t", {31'd0, ps2_dat_t}, 32'd1);
    check("rst_pad_o", {30'd0, ps2_clk_o, ps2_dat_o}, 32'd0);
    check("rst_tx_ready", {31'd0, bus.tx_ready_o}, 32'd0);
    check("rst_rx_valid_irq", {30'd0, bus.rx_valid_o, irq}, 32'd0);
    rst = 1'b0;
    tick(1);
    check("idle_tx_ready", {31'd0, bus.tx_ready_o}, 32'd1);

    // Good frame 0x1C, odd parity bit 0
    exp_q.push_back(8'h1C);
    dev_send(8'h1C, 1'b0, 1'b0);
    check("rx_valid_1c", {31'd0, bus.rx_valid_o}, 32'd1);
    check("irq_1c", {31'd0, irq}, 32'd1);
    bus.rx_ready_i = 1'b1;
    tick(1);
    bus.rx_ready_i = 1'b0;
    tick(3);
    check("rx_drained", {30'd0, bus.rx_valid_o, irq}, 32'd0);
    check("rx_err_none", rx_err_cnt, 0);

    // Bad parity
    dev_send(8'h1C, 1'b1, 1'b0);
    check("rx_err_parity", rx_err_cnt, 1);
    check("rx_bad_no_push", {31'd0, bus.rx_valid_o}, 32'd0);
    check("rx_bad_idle", {31'd0, bus.tx_ready_o}, 32'd1);

    // Host sends 0xFF with ACK
    host_start(8'hFF);
    dev_host_rx(1'b1, 10, got);
    check("tx_ff_bits", {22'd0, got}, {22'd0, 2'b11, 8'hFF});
    n = 0;
    while (!bus.tx_ready_o && n < 200) begin tick(1); n++; end
    check("tx_ff_ready_back", {31'd0, bus.tx_ready_o}, 32'd1);
    check("tx_ff_no_err", tx_err_cnt, 0);

    // Host sends 0xED, no ACK
    host_start(8'hED);
    dev_host_rx(1'b0, 11, got);
    check("tx_ed_bits", {22'd0, got}, {22'd0, 2'b11, 8'hED});
    tick(20);
    check("tx_noack_err", tx_err_cnt, 1);

    // Device stops clocking mid-frame
    host_start(8'hED);
    dev_host_rx(1'b0, 3, got);
    tick(TMO + 100);
    check("tx_timeout_err", tx_err_cnt, 2);
    check("tx_timeout_lines", {30'd0, ps2_clk_t, ps2_dat_t}, 32'b11);
    check("tx_timeout_idle", {31'd0, bus.tx_ready_o}, 32'd1);

    // Fill FIFO, overflow on the fifth byte
    e_rx = rx_err_cnt;
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
    dev_send(8'h01, 1'b0, 1'b0);
    dev_send(8'h02, 1'b0, 1'b0);
    dev_send(8'h03, 1'b1, 1'b0);
    dev_send(8'h04, 1'b0, 1'b0);
    dev_send(8'h05, 1'b1, 1'b0);
    check("ovf_once", ovf_cnt, 1);
    check("ovf_no_rx_err", rx_err_cnt, e_rx);
    check("ovf_irq", {31'd0, irq}, 32'd1);
    exp_q.push_back(8'h06);
    dev_send(8'h06, 1'b1, 1'b1);
    check("full_pushpop_no_ovf", ovf_cnt, 1);
    check("full_still_valid", {31'd0, bus.rx_valid_o}, 32'd1);
    bus.rx_ready_i = 1'b1;
    tick(6);
    bus.rx_ready_i = 1'b0;
    tick(2);
    check("fifo_all_popped", exp_q.size(), 0);
    check("fifo_empty", {31'd0, bus.rx_valid_o}, 32'd0);

    // Reset during TX bit 4 of 0x52 (bit 3 = 0 is on the line)
    e_rx = rx_err_cnt; e_ovf = ovf_cnt; e_tx = tx_err_cnt;
    host_start(8'h52);
    dev_host_rx(1'b0, 4, got);
    check("tx52_bit3_low", {31'd0, ps2_dat_t}, 32'd0);
    rst = 1'b1;
    tick(1);
    check("rst_mid_lines", {30'd0, ps2_clk_t, ps2_dat_t}, 32'b11);
    check("rst_mid_ready", {31'd0, bus.tx_ready_o}, 32'd0);
    tick(3);
    rst = 1'b0;
    tick(1);
    check("post_rst_idle", {31'd0, bus.tx_ready_o}, 32'd1);
    tick(50);
    check("post_rst_empty", {30'd0, bus.rx_valid_o, irq}, 32'd0);
    check("post_rst_pulses", (rx_err_cnt - e_rx) + (ovf_cnt - e_ovf) + (tx_err_cnt - e_tx), 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
